// File: rtl/alu_pkg.sv
// alu_pkg: opcode and sequencer state codes shared by the ALU and its sequencer.
package alu_pkg;
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_SHOW = 3'd4;
    function automatic logic is_legal_op(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
    endfunction
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: operand/opcode/strobe bus between the sequencer and the ALU.
interface alu_seq_ctrl_if #(parameter int NB_DATA = 4, parameter int NB_OP = 6);
    logic [NB_DATA-1:0] dato_a;
    logic [NB_DATA-1:0] dato_b;
    logic [NB_OP-1:0]   op;
    logic               valid;
    logic [NB_DATA-1:0] result;
    modport master(output dato_a, dato_b, op, valid, input result);
    modport slave(input dato_a, dato_b, op, valid, output result);
endinterface

// File: rtl/alu_seq_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-count debouncer and rising-edge pulse for the load button.
module btn_debounce #(parameter int DB_CYCLES = 16) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_evt
);
    localparam int NB_CNT = $clog2(DB_CYCLES + 1);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DB_CYCLES - 1);
    logic sync1_q, sync2_q, level_q, level_d, evt_q, evt_d, diff;
    logic [NB_CNT-1:0] cnt_q, cnt_d;
    always_comb begin
        diff    = sync2_q != level_q;
        cnt_d   = (diff && cnt_q != CNT_LAST) ? cnt_q + 1'b1 : '0;
        level_d = (diff && cnt_q == CNT_LAST) ? sync2_q : level_q;
        evt_d   = level_d & ~level_q;
    end
    always_ff @(posedge clk) begin
        if (i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            evt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
        end
    end
    assign o_evt = evt_q;
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: button-stepped sequencer capturing operand A, operand B and opcode,
// then strobing the ALU once and latching its result for display.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int NB_DATA   = 4,
    parameter int NB_OP     = 6,
    parameter int DB_CYCLES = 16
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_OP-1:0]   i_dato,
    input  logic               i_btn,
    input  logic               i_abort,
    alu_seq_ctrl_if.master     alu,
    output logic [NB_DATA-1:0] o_result,
    output logic [2:0]         o_state,
    output logic               o_err,
    output logic               o_done
);
    logic btn_evt, ld, legal, exec;
    logic [2:0] state_q, state_d;
    logic [NB_DATA-1:0] dato_a_q, dato_a_d, dato_b_q, dato_b_d, result_q, result_d;
    logic [NB_OP-1:0] op_q, op_d;
    logic valid_q, valid_d, done_q, done_d, err_q, err_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (.clk(clk), .i_rst(i_rst), .i_btn(i_btn), .o_evt(btn_evt));

    always_ff @(posedge clk) begin
        if (i_rst) state_q <= S_A;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_abort) state_d = S_A;
        else case (state_q)
            S_A:    state_d = btn_evt ? S_B : S_A;
            S_B:    state_d = btn_evt ? S_OP : S_B;
            S_OP:   state_d = (btn_evt && legal) ? S_EXEC : S_OP;
            S_EXEC: state_d = S_SHOW;
            S_SHOW: state_d = btn_evt ? S_A : S_SHOW;
            default: state_d = S_A;
        endcase
    end

    always_comb begin
        ld       = btn_evt && !i_abort;
        legal    = is_legal_op(6'(i_dato));
        exec     = state_q == S_EXEC && !i_abort;
        dato_a_d = (state_q == S_A && ld) ? i_dato[NB_DATA-1:0] : dato_a_q;
        dato_b_d = (state_q == S_B && ld) ? i_dato[NB_DATA-1:0] : dato_b_q;
        op_d     = (state_q == S_OP && ld && legal) ? i_dato : op_q;
        err_d    = (i_abort || (state_q == S_A && ld)) ? 1'b0 : (state_q == S_OP && ld) ? !legal : err_q;
        valid_d  = state_d == S_EXEC;
        result_d = exec ? alu.result : result_q;
        done_d   = exec;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            dato_a_q <= '0;
            dato_b_q <= '0;
            op_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            dato_a_q <= dato_a_d;
            dato_b_q <= dato_b_d;
            op_q     <= op_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Abort masks the strobes in the very cycle it arrives, including an abort during S_EXEC.
    assign alu.valid  = valid_q & ~i_abort;
    assign o_done     = done_q & ~i_abort;
    assign alu.dato_a = dato_a_q;
    assign alu.dato_b = dato_b_q;
    assign alu.op     = op_q;
    assign o_result   = result_q;
    assign o_state    = state_q;
    assign o_err      = err_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed checks of reset, load sequence, debounce, illegal op, abort and repeat.
module tb_alu_seq_ctrl;
    import alu_pkg::*;
    logic clk = 1'b0, i_rst = 1'b1, i_btn = 1'b0, i_abort = 1'b0;
    logic [5:0] i_dato = '0;
    logic [3:0] alu_res = '0;
    logic [3:0] o_result;
    logic [2:0] o_state;
    logic o_err, o_done, pv = 1'b0, pd = 1'b0;
    int n_chk = 0, n_err = 0, valid_cnt = 0, done_cnt = 0, dbl = 0, valid_off = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.NB_DATA(4), .NB_OP(6)) bus ();
    assign bus.result = alu_res;

    alu_seq_ctrl #(.NB_DATA(4), .NB_OP(6), .DB_CYCLES(4)) dut (
        .clk(clk), .i_rst(i_rst), .i_dato(i_dato), .i_btn(i_btn), .i_abort(i_abort),
        .alu(bus), .o_result(o_result), .o_state(o_state), .o_err(o_err), .o_done(o_done)
    );

    always @(negedge clk) begin
        if (!i_rst) begin
            if (bus.valid == 1'b1) valid_cnt++;
            if (o_done == 1'b1) done_cnt++;
            if ((bus.valid == 1'b1 && pv) || (o_done == 1'b1 && pd)) dbl++;
            if (bus.valid == 1'b1 && o_state != S_EXEC) valid_off++;
        end
        pv = bus.valid == 1'b1;
        pd = o_done == 1'b1;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [5:0] v);
        i_dato = v;
        i_btn  = 1'b1;
        tick(12);
        i_btn  = 1'b0;
        tick(12);
    endtask

    initial begin
        i_btn  = 1'b1;
        i_dato = 6'h0A;
        tick(2);
        chk("rst_state", o_state, 0);
        chk("rst_a", bus.dato_a, 0);
        chk("rst_b", bus.dato_b, 0);
        chk("rst_op", bus.op, 0);
        chk("rst_res", o_result, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_err", o_err, 0);
        chk("rst_done", o_done, 0);
        i_rst = 1'b0;
        tick(12);
        chk("held_evt_state", o_state, 1);
        chk("held_evt_a", bus.dato_a, 4'hA);
        i_btn = 1'b0;
        tick(12);
        chk("held_single_evt", o_state, 1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_state", o_state, 0);
        chk("abort_keep_a", bus.dato_a, 4'hA);

        valid_cnt = 0;
        done_cnt  = 0;
        press(6'h35);
        press(6'h03);
        alu_res = 4'h8;
        press(OP_ADD);
        chk("add_state", o_state, 4);
        chk("add_a", bus.dato_a, 4'h5);
        chk("add_b", bus.dato_b, 4'h3);
        chk("add_op", bus.op, OP_ADD);
        chk("add_res", o_result, 4'h8);
        chk("add_valid_cnt", valid_cnt, 1);
        chk("add_done_cnt", done_cnt, 1);
        press(6'h00);
        chk("show_to_a", o_state, 0);

        i_dato = 6'h07;
        for (int i = 0; i < 10; i++) begin
            i_btn = ~i_btn;
            tick();
        end
        i_btn = 1'b1;
        tick(12);
        i_btn = 1'b0;
        tick(12);
        chk("bounce_state", o_state, 1);
        chk("bounce_a", bus.dato_a, 4'h7);
        i_dato = 6'h0F;
        i_btn  = 1'b1;
        tick(3);
        i_btn  = 1'b0;
        tick(12);
        chk("glitch_state", o_state, 1);
        chk("glitch_b", bus.dato_b, 4'h3);

        press(6'h02);
        chk("b_state", o_state, 2);
        press(6'b111111);
        chk("ill_err", o_err, 1);
        chk("ill_state", o_state, 2);
        chk("ill_op_kept", bus.op, OP_ADD);
        alu_res = 4'hE;
        press(OP_SUB);
        chk("sub_err", o_err, 0);
        chk("sub_state", o_state, 4);
        chk("sub_op", bus.op, OP_SUB);
        chk("sub_res", o_result, 4'hE);
        chk("sub_valid_cnt", valid_cnt, 2);

        press(6'h00);
        press(6'h09);
        chk("pre_abort_state", o_state, 1);
        i_dato = 6'h0C;
        i_btn  = 1'b1;
        tick(6);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abevt_state", o_state, 0);
        chk("abevt_b", bus.dato_b, 4'h2);
        chk("abevt_a", bus.dato_a, 4'h9);
        i_btn = 1'b0;
        tick(12);
        chk("abevt_dropped", o_state, 0);
        chk("abevt_valid_cnt", valid_cnt, 2);

        press(6'h01);
        press(6'h04);
        alu_res = 4'h5;
        press(OP_AND);
        chk("b2b_state", o_state, 4);
        chk("b2b_a", bus.dato_a, 4'h1);
        chk("b2b_res", o_result, 4'h5);
        chk("b2b_valid_cnt", valid_cnt, 3);
        chk("b2b_done_cnt", done_cnt, 3);
        chk("no_double_pulse", dbl, 0);
        chk("valid_in_exec", valid_off, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
